// File: rtl/pooling_layer_output_buffer.sv
// Serial-to-parallel collector: packs OUTPUT_SIZE pooled words into one vector,
// first received word in the MSB slot, early close on in_last with zero fill.
module pooling_layer_output_buffer #(
  parameter int unsigned OUTPUT_SIZE = 3,
  parameter int unsigned DATA_WIDTH  = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              in_valid,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_last,
  output logic                              in_ready,
  output logic                              out_valid,
  output logic [OUTPUT_SIZE*DATA_WIDTH-1:0] out_data,
  input  logic                              out_ready,
  output logic                              out_padded
);

  localparam int unsigned CW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
  localparam int unsigned VW = OUTPUT_SIZE * DATA_WIDTH;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [VW-1:0]   data_q, data_d;
  logic            padded_q, padded_d;

  // Next-state, slot write and handshake logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    padded_d = padded_q;
    in_ready = 1'b0;

    if (state_q == COLLECT) begin
      in_ready = !flush;
      if (flush) begin
        cnt_d  = '0;
        data_d = '0;
      end else if (in_valid) begin
        for (int unsigned k = 0; k < OUTPUT_SIZE; k++) begin
          if (cnt_q == CW'(k)) begin
            data_d[(OUTPUT_SIZE-k)*DATA_WIDTH-1 -: DATA_WIDTH] = in_data;
          end
        end
        if (cnt_q == CW'(OUTPUT_SIZE-1)) begin
          state_d  = FULL;
          cnt_d    = '0;
          padded_d = 1'b0;
        end else if (in_last) begin
          // Tail slots were cleared when the previous vector left
          state_d  = FULL;
          cnt_d    = '0;
          padded_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end else begin
      in_ready = out_ready;
      if (out_ready) begin
        state_d  = COLLECT;
        data_d   = '0;
        padded_d = 1'b0;
        cnt_d    = '0;
        if (in_valid) begin
          data_d[VW-1 -: DATA_WIDTH] = in_data;
          if (in_last) begin
            state_d  = FULL;
            padded_d = 1'b1;
          end else begin
            cnt_d = CW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= COLLECT;
      cnt_q    <= '0;
      data_q   <= '0;
      padded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      padded_q <= padded_d;
    end
  end

  assign out_valid  = (state_q == FULL);
  assign out_data   = data_q;
  assign out_padded = padded_q;

endmodule

// File: tb/tb_pooling_layer_output_buffer.sv
// Bench for pooling_layer_output_buffer: queue-based vector model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_pooling_layer_output_buffer;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int VW = N * DW;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_last, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid, out_padded;
  logic [VW-1:0] out_data;

  pooling_layer_output_buffer #(.OUTPUT_SIZE(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .out_padded(out_padded)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;
  logic rdy_seen;

  // Model: words gathered so far, plus at most one completed vector awaiting drain
  logic [DW-1:0] part[$];
  bit            pend_v   = 1'b0;
  logic [VW-1:0] pend_vec = '0;
  bit            pend_pad = 1'b0;
  int            m_xfers  = 0;
  int            d_xfers  = 0;

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [VW-1:0] pack_part();
    logic [VW-1:0] v = '0;
    for (int k = 0; k < part.size(); k++) v = v | (VW'(part[k]) << ((N-1-k)*DW));
    return v;
  endfunction

  task automatic close_vec();
    pend_vec = pack_part();
    pend_pad = (part.size() < N);
    pend_v   = 1'b1;
    part.delete();
  endtask

  always @(posedge clk) begin
    if (rst) begin
      part.delete();
      pend_v = 1'b0; pend_vec = '0; pend_pad = 1'b0;
    end else if (pend_v) begin
      if (out_ready) begin
        pend_v = 1'b0;
        if (in_valid) begin
          part.push_back(in_data);
          if (in_last || part.size() == N) close_vec();
        end
      end
    end else if (flush) begin
      part.delete();
    end else if (in_valid) begin
      part.push_back(in_data);
      if (in_last || part.size() == N) close_vec();
    end
  end

  // Compare process; inputs and registered outputs are stable at the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", VW'(in_ready), VW'(pend_v ? out_ready : !flush));
      chk("out_valid", VW'(out_valid), VW'(pend_v));
      chk("out_data", out_data, pend_v ? pend_vec : pack_part());
      if (pend_v) chk("out_padded", VW'(out_padded), VW'(pend_pad));
      if (!rst && out_valid && out_ready) d_xfers++;
      if (!rst && pend_v && out_ready) m_xfers++;
    end
  end

  task automatic step(input bit r, input bit f, input bit v, input logic [DW-1:0] d,
                      input bit l, input bit ordy);
    rst = r; flush = f; in_valid = v; in_data = d; in_last = l; out_ready = ordy;
    #2 rdy_seen = in_ready;
    @(posedge clk); #1;
  endtask

  task automatic word(input logic [DW-1:0] d, input bit l, input bit ordy);
    step(1'b0, 1'b0, 1'b1, d, l, ordy);
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 1'b0, 1'b0, $urandom, 1'b0, ordy);
  endtask

  int  x0;
  bit  any_low;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("reset out_valid", VW'(out_valid), '0);
    chk("reset out_data", out_data, '0);
    chk("reset out_padded", VW'(out_padded), '0);

    // Basic pack
    word(32'h3F800000, 1'b0, 1'b1);
    word(32'h40000000, 1'b0, 1'b1);
    word(32'h40400000, 1'b0, 1'b1);
    chk("basic valid", VW'(out_valid), VW'(1));
    chk("basic data", out_data, 96'h3F800000_40000000_40400000);
    chk("basic padded", VW'(out_padded), '0);
    idle(1'b1);
    chk("basic drained valid", VW'(out_valid), '0);
    chk("basic drained data", out_data, '0);

    // Early close
    word(32'h3F800000, 1'b0, 1'b1);
    word(32'h40000000, 1'b1, 1'b1);
    chk("early data", out_data, 96'h3F800000_40000000_00000000);
    chk("early padded", VW'(out_padded), VW'(1));
    idle(1'b1);

    // Back-pressure then flow-through accept on the drain cycle
    word(32'h40A00000, 1'b0, 1'b0);
    word(32'h40C00000, 1'b0, 1'b0);
    word(32'h40E00000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      word(32'h40800000, 1'b0, 1'b0);
      chk("bp in_ready", VW'(rdy_seen), '0);
      chk("bp data held", out_data, 96'h40A00000_40C00000_40E00000);
    end
    word(32'h40800000, 1'b0, 1'b1);
    chk("bp drain in_ready", VW'(rdy_seen), VW'(1));
    chk("bp after valid", VW'(out_valid), '0);
    chk("bp after data", out_data, 96'h40800000_00000000_00000000);
    word(32'h41000000, 1'b0, 1'b1);
    word(32'h41100000, 1'b0, 1'b1);
    chk("bp cnt1 vector", out_data, 96'h40800000_41000000_41100000);
    idle(1'b1);

    // Flush drops the partial vector and the same-cycle word
    word(32'h3F800000, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 32'h40000000, 1'b0, 1'b1);
    chk("flush in_ready", VW'(rdy_seen), '0);
    chk("flush data", out_data, '0);
    word(32'h41200000, 1'b0, 1'b1);
    word(32'h41300000, 1'b0, 1'b1);
    word(32'h41400000, 1'b0, 1'b1);
    chk("flush clean vector", out_data, 96'h41200000_41300000_41400000);
    chk("flush clean padded", VW'(out_padded), '0);
    idle(1'b1);

    // Reset mid-vector and while FULL with out_ready high
    word(32'h3F800000, 1'b0, 1'b1);
    word(32'h40000000, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("rst mid data", out_data, '0);
    chk("rst mid valid", VW'(out_valid), '0);
    word(32'h3F800000, 1'b0, 1'b0);
    word(32'h40000000, 1'b0, 1'b0);
    word(32'h40400000, 1'b0, 1'b0);
    chk("rst full pre", VW'(out_valid), VW'(1));
    x0 = d_xfers;
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("rst full valid", VW'(out_valid), '0);
    chk("rst full no xfer", VW'(d_xfers), VW'(x0));
    idle(1'b1);

    // Continuous stream of 12 words
    x0 = d_xfers;
    any_low = 1'b0;
    for (int i = 0; i < 12; i++) begin
      word($urandom, 1'b0, 1'b1);
      if (!rdy_seen) any_low = 1'b1;
    end
    idle(1'b1);
    idle(1'b1);
    chk("stream vectors", VW'(d_xfers - x0), VW'(4));
    chk("stream in_ready low", VW'(any_low), '0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(99) == 0, $urandom_range(19) == 0, $urandom_range(3) != 0,
           $urandom, $urandom_range(5) == 0, $urandom_range(9) < 7);
    end
    idle(1'b1);
    idle(1'b1);
    chk("transfer count", VW'(d_xfers), VW'(m_xfers));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/pooling_layer_output_buffer.md
Name: pooling_layer_output_buffer

Overview:
- Serial-to-parallel collector at the output of the pooling layer.
- Accepts pooled results one `DATA_WIDTH word per handshake and packs OUTPUT_SIZE words into one parallel vector for the next layer's input stage.
- Packing order: the first word received is the first word the downstream parallel-to-serial input buffer will emit.

Parameters:
- OUTPUT_SIZE, 3: words per output vector; legal range 2..16.
- DATA_WIDTH, `DATA_WIDTH (32): word width, IEEE-754 single-precision bit pattern. Passed through untouched, no arithmetic.

Ports:
- clk  input  1  single clock; all state changes on posedge.
- rst  input  1  reset; synchronous, active-high.
- flush  input  1  discards any partial vector; see rules.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  DATA_WIDTH  pooled result word.
- in_last  input  1  qualified by in_valid; this is the final word of the row.
- in_ready  output  1  block accepts a word this cycle.
- out_valid  output  1  out_data holds a complete vector.
- out_data  output  OUTPUT_SIZE*DATA_WIDTH  packed vector; slot k at bits [(OUTPUT_SIZE-k)*DATA_WIDTH-1 -: DATA_WIDTH]; slot 0 is at the MSBs and is the first word received.
- out_ready  input  1  downstream accepts the vector.
- out_padded  output  1  valid with out_valid; vector was closed early by in_last and zero-filled.

Behaviour:
- Handshakes:
  - Input accepted when in_valid & in_ready.
  - Output transferred when out_valid & out_ready.
- Counter:
  - cnt, width $clog2(OUTPUT_SIZE), holds the next slot index.
- States:
  - COLLECT: in_ready=1, out_valid=0.
  - FULL: out_valid=1; in_ready=out_ready, giving flow-through on the drain cycle.
- Reset (rst=1 at posedge):
  - state=COLLECT, cnt=0, out_data=0, out_valid=0, out_padded=0.
  - Takes priority over all other inputs, including mid-vector or while FULL with out_ready high.
  - Any partial or pending vector is lost.
- COLLECT, word accepted:
  - slot[cnt] <= in_data.
  - If cnt==OUTPUT_SIZE-1: go to FULL, cnt<=0, out_padded<=0.
  - Else if in_last: go to FULL, cnt<=0, out_padded<=1. Slots cnt+1..OUTPUT_SIZE-1 are already 0.
  - Else cnt<=cnt+1.
- COLLECT, in_last on slot OUTPUT_SIZE-1: full vector, out_padded=0.
- Latency: out_valid rises the cycle after the posedge that accepts the closing word.
- FULL:
  - out_data and out_padded are held stable until the output transfer.
  - On transfer with no input accept: out_data<=0, go to COLLECT.
  - On transfer with simultaneous input accept (in_ready=out_ready=1):
    - out_data <= {in_data, zeros}, cnt<=1, state=COLLECT.
    - If additionally in_last, or OUTPUT_SIZE==1 (illegal), the vector closes again: out_data={in_data,0...}, out_padded=1, remain FULL.
  - No input accepted while FULL and out_ready=0 (back-pressure).
- Unwritten slots always read 0, so out_data during COLLECT shows the partial vector with zero tail. Downstream must ignore out_data when out_valid=0.
- flush (lower priority than rst):
  - In COLLECT: cnt<=0, out_data<=0; any same-cycle input word is dropped and in_ready is forced to 0.
  - In FULL: no effect; the complete vector is not discarded.
- in_last with in_valid=0 is ignored.
- No overflow possible: cnt never exceeds OUTPUT_SIZE-1 by construction.
- in_data X while in_valid=0 must not propagate into out_data.

Test Plan:
- Basic pack: after reset, send 0x3F800000, 0x40000000, 0x40400000 on consecutive cycles with out_ready=1 -> out_valid high one cycle after the third accept; out_data=0x3F800000_40000000_40400000, out_padded=0, then out_valid low and out_data=0.
- Early close: send 0x3F800000 then 0x40000000 with in_last=1 -> out_data=0x3F800000_40000000_00000000, out_padded=1.
- Back-pressure: complete a vector with out_ready=0 for 5 cycles while in_valid=1 with 0x40800000 -> in_ready=0 for all 5 cycles, out_data stable. Raise out_ready -> vector transfers and 0x40800000 is accepted the same cycle; next state COLLECT with cnt=1, out_data=0x40800000_00000000_00000000.
- Flush: accept 0x3F800000, then pulse flush together with in_valid 0x40000000 -> word dropped, cnt=0; the next 3 words form a clean vector with no 0x3F800000.
- Reset mid-operation: accept 2 words, assert rst one cycle -> all outputs 0, cnt=0. Also assert rst while FULL with out_ready=1 -> no transfer counted, out_valid=0 the next cycle.
- Continuous stream: 12 words back-to-back with out_ready=1 -> exactly 4 vectors in order, in_ready never low, no word lost or duplicated.
